// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder.
//   state_t       : FSM encoding (IDLE=0, RUN=1, DONE=2), 2 bits.
//   DEFAULT_WIDTH : default operand/sum width.
//   DEFAULT_CHUNK : default bits added per cycle.
//   idx_width()   : width of the chunk index for a given chunk count (minimum 1).
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CHUNK = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder.
//   x, y     : CHUNK-bit addends
//   ci       : carry in
//   s        : CHUNK-bit sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (XOR with co gives signed overflow)
module chunk_adder #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co       = c[CHUNK];
        c_msb_in = c[CHUNK-1];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin an operation (only sampled in IDLE)
//   a, b     : WIDTH-bit operands
//   cin      : carry-in for add mode (ignored when sub=1)
//   sub      : 0 = a+b+cin, 1 = a-b
//   busy     : high in RUN and DONE
//   done     : one-cycle pulse, result valid
//   sum      : WIDTH-bit result, held until the next accepted start
//   carry    : unsigned carry-out (1 = no borrow when subtracting)
//   overflow : two's-complement overflow
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = idx_width(N);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("seq_chunk_adder: WIDTH must be at least 2");
    end
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("seq_chunk_adder: CHUNK must divide WIDTH exactly");
    end

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;   // already inverted in subtract mode
    logic             c_q;   // running carry between chunks

    logic [IW-1:0]    base;
    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] y_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
    logic             cmsb_chunk;

    always_comb begin
        base    = IW'(32'(k_q) * CHUNK);
        x_chunk = a_q[base +: CHUNK];
        y_chunk = b_q[base +: CHUNK];
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .x        (x_chunk),
        .y        (y_chunk),
        .ci       (c_q),
        .s        (s_chunk),
        .co       (co_chunk),
        .c_msb_in (cmsb_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        // Subtraction is a + ~b + 1, so cin is forced high.
                        b_q      <= sub ? ~b : b;
                        c_q      <= sub | cin;
                        k_q      <= '0;
                        sum      <= '0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: CHUNK] <= s_chunk;
                    c_q                <= co_chunk;
                    if (k_q == KLast) begin
                        carry    <= co_chunk;
                        overflow <= co_chunk ^ cmsb_chunk;
                        done     <= 1'b1;
                        k_q      <= '0;
                        state_q  <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: three instances (8/2, 16/4, 8/8) share operand
// inputs and reset; each has its own start. Expected results are queued at issue time
// and popped by a monitor on every done pulse.
module tb_seq_chunk_adder;

    typedef struct {
        int          d;
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;
    logic        sub_i;
    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        carry_v [3];
    logic        ovf_v   [3];
    logic [7:0]  sum_d0;
    logic [15:0] sum_d1;
    logic [7:0]  sum_d2;
    logic [15:0] sum_v   [3];

    int   w_of [3] = '{8, 16, 8};
    int   n_of [3] = '{4, 4, 1};
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   done_cnt [3] = '{0, 0, 0};
    int   pushed   [3] = '{0, 0, 0};
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        sum_v[0] = {8'h00, sum_d0};
        sum_v[1] = sum_d1;
        sum_v[2] = {8'h00, sum_d2};
    end

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_i[7:0]), .b(b_i[7:0]),
        .cin(cin_i), .sub(sub_i), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_d0),
        .carry(carry_v[0]), .overflow(ovf_v[0])
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_i), .b(b_i),
        .cin(cin_i), .sub(sub_i), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_d1),
        .carry(carry_v[1]), .overflow(ovf_v[1])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_i[7:0]), .b(b_i[7:0]),
        .cin(cin_i), .sub(sub_i), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_d2),
        .carry(carry_v[2]), .overflow(ovf_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: unsigned sum/carry and signed overflow for width w.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         output logic [15:0] s, output logic c, output logic o);
        logic [16:0] full;
        logic [15:0] mask;
        logic [15:0] am;
        logic [15:0] bm;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        am   = a & mask;
        bm   = b & mask;
        if (!sub) full = {1'b0, am} + {1'b0, bm} + {16'h0000, cin};
        else      full = {1'b0, am} + {1'b0, ~bm & mask} + 17'd1;
        s = full[15:0] & mask;
        c = (w == 16) ? full[16] : full[8];
        if (!sub) o = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        else      o = (am[w-1] != bm[w-1]) && (s[w-1] != am[w-1]);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy_v[d] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout dut%0d: busy=%b after 100 cycles, expected 0", d,
                     busy_v[d]);
        end
    endtask

    // Called at a negedge; start is sampled by the following posedge.
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo, input bit push);
        wait_idle(d);
        a_i        = a;
        b_i        = b;
        cin_i      = cin;
        sub_i      = sub;
        start_v[d] = 1'b1;
        if (push) begin
            exp_q.push_back('{d, es, ec, eo, cyc});
            pushed[d]++;
        end
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_v[d] === 1'b1) begin
                done_cnt[d]++;
                if (exp_q.size() == 0 || exp_q[0].d != d) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done dut%0d: done=1 at cycle %0d, expected 0",
                             d, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("sum_dut%0d", d), 32'(sum_v[d]), 32'(e.s));
                    check($sformatf("carry_dut%0d", d), 32'(carry_v[d]), 32'(e.c));
                    check($sformatf("overflow_dut%0d", d), 32'(ovf_v[d]), 32'(e.o));
                    check($sformatf("latency_dut%0d", d), 32'(cyc - e.cyc), 32'(n_of[d] + 1));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        int          c0;

        rst = 1'b1;
        a_i = '0;
        b_i = '0;
        cin_i = 1'b0;
        sub_i = 1'b0;
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy_v[0]), 0);
        check("reset_done", 32'(done_v[0]), 0);
        check("reset_sum", 32'(sum_v[0]), 0);
        check("reset_carry", 32'(carry_v[0]), 0);
        check("reset_overflow", 32'(ovf_v[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors on the 8-bit / 2-bit-chunk instance.
        issue(0, 100, 100, 1, 0, 201, 0, 1, 1);
        issue(0, 200, 200, 0, 0, 144, 1, 0, 1);
        issue(0, 34, 214, 1, 0, 249, 0, 0, 1);
        issue(0, 100, 50, 1, 1, 50, 1, 0, 1);
        issue(0, 127, 1, 0, 0, 128, 0, 1, 1);
        issue(0, 128, 1, 0, 1, 127, 1, 1, 1);
        issue(0, 0, 0, 0, 1, 0, 1, 0, 1);
        issue(0, 255, 0, 1, 0, 0, 1, 0, 1);
        issue(0, 10, 3, 0, 1, 7, 1, 0, 1);
        issue(0, 50, 100, 1, 1, 206, 0, 0, 1);

        // Result must hold after done.
        wait_idle(0);
        repeat (3) @(negedge clk);
        check("hold_sum", 32'(sum_v[0]), 206);
        check("hold_carry", 32'(carry_v[0]), 0);

        // Second start during RUN with new operands is ignored.
        issue(0, 20, 30, 0, 0, 50, 0, 0, 1);
        @(negedge clk);
        a_i = 1;
        b_i = 1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);

        // start held high: a second operation begins in the first IDLE cycle after DONE.
        a_i = 128;
        b_i = 128;
        cin_i = 1'b0;
        sub_i = 1'b0;
        c0 = cyc;
        start_v[0] = 1'b1;
        exp_q.push_back('{0, 16'd0, 1'b1, 1'b1, c0});
        exp_q.push_back('{0, 16'd0, 1'b1, 1'b1, c0 + 6});
        pushed[0] += 2;
        repeat (7) @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);

        // Reset in the third RUN cycle aborts with no done.
        issue(0, 9, 9, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_v[0]), 0);
        check("abort_done", 32'(done_v[0]), 0);
        check("abort_sum", 32'(sum_v[0]), 0);
        check("abort_carry", 32'(carry_v[0]), 0);
        check("abort_overflow", 32'(ovf_v[0]), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 55, 156, 1, 0, 212, 0, 0, 1);
        wait_idle(0);

        // Random regressions on 16/4 and 8/8 against the reference model.
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 12; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                if (w_of[d] == 8) begin
                    ra = ra & 16'h00FF;
                    rb = rb & 16'h00FF;
                end
                model(w_of[d], ra, rb, rc, rs, es, ec, eo);
                issue(d, ra, rb, rc, rs, es, ec, eo, 1);
            end
            wait_idle(d);
        end

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("done_count_dut%0d", d), 32'(done_cnt[d]), 32'(pushed[d]));
        end
        check("pending_results", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
